multi_ch_feeder: RTL and testbench

MULTI_CH_FEEDER -- requirements
Module: multi_ch_feeder

---
 rtl/multi_ch_feeder.sv | 129 ++++++++++++
 tb/tb_multi_ch_feeder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/multi_ch_feeder.sv
// rtl/multi_ch_feeder.sv - round-robin stack feeder driving a loader/drawer pair.
// Optional wait-state timeout is compiled in with FEEDER_TIMEOUT_EN.
module multi_ch_feeder #(
   parameter int N_CH           = 4,
   parameter int CH_W           = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic [N_CH-1:0] stack_empty,
   output logic [N_CH-1:0] pop,
   output logic            load,
   output logic [CH_W-1:0] load_ch,
   input  logic            load_finish,
   input  logic            draw_finish,
   output logic            busy,
   output logic            timeout_err
);

   typedef enum logic [1:0] {IDLE, LOAD, DRAW} state_t;

   state_t            state, state_nx;
   logic [CH_W-1:0]   last_grant, last_grant_nx;
   logic [CH_W-1:0]   grant, load_ch_nx;
   logic              found;
   logic [N_CH-1:0]   pop_nx;
   logic              load_nx, busy_nx, terr_nx;
   logic              expired;

`ifdef FEEDER_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] wait_cnt;

   // Counter restarts on every state change, so LOAD and DRAW each get a full budget.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         wait_cnt <= '0;
      else if (state_nx != state || state == IDLE)
         wait_cnt <= '0;
      else
         wait_cnt <= wait_cnt + CNT_W'(1);
   end

   assign expired = (state != IDLE) && (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign expired = 1'b0;
`endif

   // Rotating priority: first non-empty stack strictly after the last served one.
   always_comb begin
      int              idx;
      logic [CH_W-1:0] idx_c;
      found = 1'b0;
      grant = '0;
      for (int k = 0; k < N_CH; k++) begin
         idx = int'(last_grant) + 1 + k;
         if (idx >= N_CH)
            idx = idx - N_CH;
         idx_c = CH_W'(idx);
         if (!found && !stack_empty[idx_c]) begin
            found = 1'b1;
            grant = idx_c;
         end
      end
   end

   always_comb begin
      state_nx      = state;
      last_grant_nx = last_grant;
      load_ch_nx    = load_ch;
      pop_nx        = '0;
      load_nx       = load;
      busy_nx       = busy;
      terr_nx       = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               pop_nx[grant] = 1'b1;
               load_nx       = 1'b1;
               busy_nx       = 1'b1;
               load_ch_nx    = grant;
               state_nx      = LOAD;
            end
         end
         LOAD: begin
            if (load_finish) begin
               load_nx  = 1'b0;
               state_nx = DRAW;
            end else if (expired) begin
               load_nx       = 1'b0;
               busy_nx       = 1'b0;
               terr_nx       = 1'b1;
               last_grant_nx = load_ch;
               state_nx      = IDLE;
            end
         end
         DRAW: begin
            if (draw_finish || expired) begin
               busy_nx       = 1'b0;
               terr_nx       = !draw_finish;
               last_grant_nx = load_ch;
               state_nx      = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         last_grant  <= CH_W'(N_CH - 1);
         load_ch     <= '0;
         pop         <= '0;
         load        <= 1'b0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= state_nx;
         last_grant  <= last_grant_nx;
         load_ch     <= load_ch_nx;
         pop         <= pop_nx;
         load        <= load_nx;
         busy        <= busy_nx;
         timeout_err <= terr_nx;
      end
   end

endmodule

// File: tb/tb_multi_ch_feeder.sv
// tb/tb_multi_ch_feeder.sv - directed table and sequence checks for multi_ch_feeder.
module tb_multi_ch_feeder;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] stack_empty = 4'b1111;
   logic [3:0] pop;
   logic       load;
   logic [1:0] load_ch;
   logic       load_finish = 1'b0;
   logic       draw_finish = 1'b0;
   logic       busy;
   logic       timeout_err;

   int errors = 0;
   int checks = 0;

   multi_ch_feeder #(.N_CH(4), .CH_W(2), .TIMEOUT_CYCLES(8)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .stack_empty (stack_empty),
      .pop         (pop),
      .load        (load),
      .load_ch     (load_ch),
      .load_finish (load_finish),
      .draw_finish (draw_finish),
      .busy        (busy),
      .timeout_err (timeout_err)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [3:0] se;
      logic       lf;
      logic       df;
      logic [3:0] pop;
      logic       load;
      logic [1:0] ch;
      logic       busy;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      stack_empty = 4'b1111;
      load_finish = 1'b0;
      draw_finish = 1'b0;
      reset_n     = 1'b0;
      repeat (2) @(posedge clock);
      #3;
      reset_n = 1'b1;
   endtask

   // {pop,load,load_ch,busy,timeout_err}
   function automatic logic [31:0] outs();
      return {23'd0, pop, load, load_ch, busy, timeout_err};
   endfunction

   function automatic logic [31:0] exp_outs(input logic [3:0] p, input logic l,
                                            input logic [1:0] c, input logic b, input logic t);
      return {23'd0, p, l, c, b, t};
   endfunction

   initial begin
      bit ok;
      int g;

      // Applied from reset (last_grant=3); each row: inputs before edge, outputs after it.
      vecs[0]  = '{4'b1011, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1};
      vecs[1]  = '{4'b1011, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd2, 1'b1};
      vecs[2]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 2'd2, 1'b1};
      vecs[3]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b1};
      vecs[4]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b1};
      vecs[5]  = '{4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd2, 1'b0};
      vecs[6]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0};
      vecs[7]  = '{4'b0000, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1};
      vecs[8]  = '{4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b1};
      vecs[9]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b1};
      vecs[10] = '{4'b0110, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0};
      vecs[11] = '{4'b0110, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1};
      vecs[12] = '{4'b0110, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1};
      vecs[13] = '{4'b0110, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};
      vecs[14] = '{4'b0110, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1};
      vecs[15] = '{4'b0110, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b1};
      vecs[16] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd3, 1'b0};
      vecs[17] = '{4'b0000, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1};
      vecs[18] = '{4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1};
      vecs[19] = '{4'b1111, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0};

      #3;
      check("reset_state", outs(), exp_outs(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0));
      #19;
      reset_n = 1'b1;

      for (int i = 0; i < 20; i++) begin
         stack_empty = vecs[i].se;
         load_finish = vecs[i].lf;
         draw_finish = vecs[i].df;
         step();
         check($sformatf("vec%0d", i), outs(),
               exp_outs(vecs[i].pop, vecs[i].load, vecs[i].ch, vecs[i].busy, 1'b0));
      end

      // Reset in the middle of LOAD on channel 1; arbitration must restart at channel 0.
      stack_empty = 4'b0000;
      load_finish = 1'b0;
      draw_finish = 1'b0;
      step();
      check("pre_reset_grant1", outs(), exp_outs(4'b0010, 1'b1, 2'd1, 1'b1, 1'b0));
      #3;
      reset_n = 1'b0;
      #1;
      check("async_reset_drop", outs(), exp_outs(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0));
      ok = 1'b1;
      repeat (3) begin
         step();
         if (pop != 4'b0000 || load || busy) ok = 1'b0;
      end
      check("reset_hold_quiet", {31'd0, ok}, 32'd1);
      #3;
      reset_n = 1'b1;
      step();
      check("post_reset_grant0", outs(), exp_outs(4'b0001, 1'b1, 2'd0, 1'b1, 1'b0));

      // Fairness from reset with every stack occupied.
      do_reset();
      stack_empty = 4'b0000;
      for (int t = 0; t < 5; t++) begin
         g = t % 4;
         step();
         check($sformatf("fair_grant%0d", t), {28'd0, pop, load, load_ch},
               {28'd0, 4'b0001 << g, 1'b1, 2'(g)});
         load_finish = 1'b1;
         step();
         load_finish = 1'b0;
         draw_finish = 1'b1;
         step();
         draw_finish = 1'b0;
      end

      // Wait-state timeout behaviour on channel 0 alone.
      do_reset();
      stack_empty = 4'b1110;
      step();
      check("to_grant", outs(), exp_outs(4'b0001, 1'b1, 2'd0, 1'b1, 1'b0));
      stack_empty = 4'b1111;
`ifdef FEEDER_TIMEOUT_EN
      ok = 1'b1;
      repeat (7) begin
         step();
         if (!load || timeout_err) ok = 1'b0;
      end
      check("to_load_held7", {31'd0, ok}, 32'd1);
      step();
      check("to_expire", outs(), exp_outs(4'b0000, 1'b0, 2'd0, 1'b0, 1'b1));
      step();
      check("to_pulse_end", {31'd0, timeout_err}, 32'd0);
      stack_empty = 4'b1110;
      step();
      check("to_regrant", outs(), exp_outs(4'b0001, 1'b1, 2'd0, 1'b1, 1'b0));
      stack_empty = 4'b1111;
      repeat (7) step();
      load_finish = 1'b1;
      step();
      load_finish = 1'b0;
      check("to_finish_wins", outs(), exp_outs(4'b0000, 1'b0, 2'd0, 1'b1, 1'b0));
      draw_finish = 1'b1;
      step();
      draw_finish = 1'b0;
      check("to_draw_done", outs(), exp_outs(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0));
`else
      ok = 1'b1;
      repeat (100) begin
         step();
         if (!load || !busy || timeout_err) ok = 1'b0;
      end
      check("no_to_load_held100", {31'd0, ok}, 32'd1);
      load_finish = 1'b1;
      step();
      load_finish = 1'b0;
      draw_finish = 1'b1;
      step();
      draw_finish = 1'b0;
      check("no_to_done", outs(), exp_outs(4'b0000, 1'b0, 2'd0, 1'b0, 1'b0));
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
